// File: rtl/pf_iod_rx_eye_train.sv
`default_nettype none
// ============================================================================
// Module   : pf_iod_rx_eye_train
// Purpose  : Sweeps the RX IOD delay line against a training word, picks the
//            widest passing window and parks the tap at its centre.
// Revision : 1.0 - initial release
// ============================================================================
module pf_iod_rx_eye_train #(
    parameter int                    DATA_WIDTH    = 8,
    parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = 8'hA5,
    parameter int                    MAX_TAP       = 127,
    parameter int                    SETTLE_CYCLES = 4,
    parameter int                    SAMPLE_CYCLES = 16,
    parameter int                    MIN_EYE       = 4
) (
    input  logic                  FAB_CLK,
    input  logic                  RESET_N,
    input  logic                  TRAIN_START,
    input  logic [DATA_WIDTH-1:0] RX_DATA,
    input  logic                  RX_DELAY_LINE_OUT_OF_RANGE,
    output logic                  DELAY_LINE_SEL,
    output logic                  DELAY_LINE_LOAD,
    output logic                  DELAY_LINE_DIRECTION,
    output logic                  DELAY_LINE_MOVE,
    output logic                  TRAIN_BUSY,
    output logic                  TRAIN_DONE,
    output logic                  TRAIN_ERR,
    output logic [7:0]            EYE_START,
    output logic [7:0]            EYE_WIDTH,
    output logic [7:0]            TAP_FINAL
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_LOAD    = 4'd1;
    localparam logic [3:0] S_SETTLE  = 4'd2;
    localparam logic [3:0] S_SAMPLE  = 4'd3;
    localparam logic [3:0] S_EVAL    = 4'd4;
    localparam logic [3:0] S_STEP    = 4'd5;
    localparam logic [3:0] S_CLOSE   = 4'd6;
    localparam logic [3:0] S_RELOAD  = 4'd7;
    localparam logic [3:0] S_PARK    = 4'd8;
    localparam logic [3:0] S_ERRLOAD = 4'd9;
    localparam logic [3:0] S_DONE    = 4'd10;

    localparam logic [7:0]  c_max_tap     = 8'(MAX_TAP);
    localparam logic [15:0] c_settle_last = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] c_sample_last = 16'(SAMPLE_CYCLES - 1);
    localparam logic [8:0]  c_min_eye     = 9'(MIN_EYE);

    logic [3:0]  r_state;
    logic [3:0]  w_next;
    logic [7:0]  r_tap;
    logic [15:0] r_cnt;
    logic        r_pass;
    // Window lengths are 9 bits: a fully open 0..255 sweep is 256 taps wide.
    logic [8:0]  r_cur_len;
    logic [8:0]  r_best_len;
    logic [7:0]  r_cur_start;
    logic [7:0]  r_best_start;
    logic [7:0]  r_target;
    logic [7:0]  r_park_left;
    logic        r_park_gap;
    logic        r_done;
    logic        r_err;
    logic [7:0]  r_eye_start;
    logic [7:0]  r_eye_width;
    logic [7:0]  r_tap_final;

    logic        w_match;
    logic        w_fold_take;
    logic [8:0]  w_fold_len;
    logic [7:0]  w_fold_start;
    logic [7:0]  w_center;
    logic        w_too_narrow;

    assign w_match      = (RX_DATA == TRAIN_PATTERN);
    // Strictly greater so the earliest window wins a tie.
    assign w_fold_take  = (r_cur_len > r_best_len);
    assign w_fold_len   = w_fold_take ? r_cur_len : r_best_len;
    assign w_fold_start = w_fold_take ? r_cur_start : r_best_start;
    assign w_center     = w_fold_start + w_fold_len[8:1];
    assign w_too_narrow = (w_fold_len < c_min_eye);

    // State register
    always_ff @(posedge FAB_CLK) begin
        if (!RESET_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (TRAIN_START) w_next = S_LOAD;
            S_LOAD:    w_next = S_SETTLE;
            S_SETTLE: begin
                if (RX_DELAY_LINE_OUT_OF_RANGE)  w_next = S_CLOSE;
                else if (r_cnt == c_settle_last) w_next = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (RX_DELAY_LINE_OUT_OF_RANGE)  w_next = S_CLOSE;
                else if (r_cnt == c_sample_last) w_next = S_EVAL;
            end
            S_EVAL:    w_next = (r_tap == c_max_tap) ? S_CLOSE : S_STEP;
            S_STEP:    w_next = S_SETTLE;
            S_CLOSE:   w_next = w_too_narrow ? S_ERRLOAD : S_RELOAD;
            S_RELOAD:  w_next = S_PARK;
            S_PARK:    if (r_park_left == 8'd0) w_next = S_DONE;
            S_ERRLOAD: w_next = S_DONE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Datapath: tap tracking, window bookkeeping and result registers
    always_ff @(posedge FAB_CLK) begin
        if (!RESET_N) begin
            r_tap        <= 8'd0;
            r_cnt        <= 16'd0;
            r_pass       <= 1'b0;
            r_cur_len    <= 9'd0;
            r_best_len   <= 9'd0;
            r_cur_start  <= 8'd0;
            r_best_start <= 8'd0;
            r_target     <= 8'd0;
            r_park_left  <= 8'd0;
            r_park_gap   <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_eye_start  <= 8'd0;
            r_eye_width  <= 8'd0;
            r_tap_final  <= 8'd0;
        end else begin
            r_cnt <= (w_next != r_state) ? 16'd0 : r_cnt + 16'd1;

            case (r_state)
                S_IDLE: begin
                    if (TRAIN_START) begin
                        r_done <= 1'b0;
                        r_err  <= 1'b0;
                    end
                end
                S_LOAD: begin
                    r_tap        <= 8'd0;
                    r_cur_len    <= 9'd0;
                    r_cur_start  <= 8'd0;
                    r_best_len   <= 9'd0;
                    r_best_start <= 8'd0;
                end
                S_SETTLE: r_pass <= 1'b1;
                S_SAMPLE: r_pass <= r_pass & w_match;
                S_EVAL: begin
                    if (r_pass) begin
                        if (r_cur_len == 9'd0) r_cur_start <= r_tap;
                        r_cur_len <= r_cur_len + 9'd1;
                    end else begin
                        r_best_len   <= w_fold_len;
                        r_best_start <= w_fold_start;
                        r_cur_len    <= 9'd0;
                    end
                end
                S_STEP: r_tap <= r_tap + 8'd1;
                S_CLOSE: begin
                    r_best_len   <= w_fold_len;
                    r_best_start <= w_fold_start;
                    r_eye_start  <= w_fold_start;
                    r_eye_width  <= w_fold_len[8] ? 8'hFF : w_fold_len[7:0];
                    r_target     <= w_too_narrow ? 8'd0 : w_center;
                    r_err        <= w_too_narrow;
                end
                S_RELOAD: begin
                    r_park_left <= r_target;
                    r_park_gap  <= 1'b0;
                end
                S_PARK: begin
                    // Alternate pulse / gap so MOVE is never high twice in a row.
                    if (r_park_left != 8'd0) begin
                        if (!r_park_gap) r_park_left <= r_park_left - 8'd1;
                        r_park_gap <= ~r_park_gap;
                    end
                end
                default: ;
            endcase

            if (w_next == S_DONE && r_state != S_DONE) begin
                r_done      <= 1'b1;
                r_tap_final <= r_target;
            end
        end
    end

    // Outputs; pulses are qualified by RESET_N so nothing moves in a reset cycle
    always_comb begin
        TRAIN_BUSY           = (r_state != S_IDLE);
        DELAY_LINE_SEL       = TRAIN_BUSY;
        DELAY_LINE_DIRECTION = TRAIN_BUSY;
        DELAY_LINE_LOAD      = RESET_N & ((r_state == S_LOAD) || (r_state == S_RELOAD) ||
                                          (r_state == S_ERRLOAD));
        DELAY_LINE_MOVE      = RESET_N & ((r_state == S_STEP) ||
                                          ((r_state == S_PARK) && (r_park_left != 8'd0) &&
                                           !r_park_gap));
        TRAIN_DONE           = r_done;
        TRAIN_ERR            = r_err;
        EYE_START            = r_eye_start;
        EYE_WIDTH            = r_eye_width;
        TAP_FINAL            = r_tap_final;
    end

endmodule
`default_nettype wire

// File: tb/tb_pf_iod_rx_eye_train.sv
`default_nettype none
// ============================================================================
// Module   : tb_pf_iod_rx_eye_train
// Purpose  : Scoreboard bench with a behavioural delay line feeding RX_DATA.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pf_iod_rx_eye_train;

    logic       FAB_CLK = 1'b0;
    logic       RESET_N;
    logic       TRAIN_START;
    logic [7:0] RX_DATA;
    logic       RX_DELAY_LINE_OUT_OF_RANGE;
    logic       DELAY_LINE_SEL, DELAY_LINE_LOAD, DELAY_LINE_DIRECTION, DELAY_LINE_MOVE;
    logic       TRAIN_BUSY, TRAIN_DONE, TRAIN_ERR;
    logic [7:0] EYE_START, EYE_WIDTH, TAP_FINAL;

    always #5 FAB_CLK = ~FAB_CLK;

    pf_iod_rx_eye_train dut (
        .FAB_CLK                    (FAB_CLK),
        .RESET_N                    (RESET_N),
        .TRAIN_START                (TRAIN_START),
        .RX_DATA                    (RX_DATA),
        .RX_DELAY_LINE_OUT_OF_RANGE (RX_DELAY_LINE_OUT_OF_RANGE),
        .DELAY_LINE_SEL             (DELAY_LINE_SEL),
        .DELAY_LINE_LOAD            (DELAY_LINE_LOAD),
        .DELAY_LINE_DIRECTION       (DELAY_LINE_DIRECTION),
        .DELAY_LINE_MOVE            (DELAY_LINE_MOVE),
        .TRAIN_BUSY                 (TRAIN_BUSY),
        .TRAIN_DONE                 (TRAIN_DONE),
        .TRAIN_ERR                  (TRAIN_ERR),
        .EYE_START                  (EYE_START),
        .EYE_WIDTH                  (EYE_WIDTH),
        .TAP_FINAL                  (TAP_FINAL)
    );

    typedef struct {
        int start;
        int width;
        int fin;
        int err;
        int park;
        int loads;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Delay-line model and eye shape
    int win_lo[2];
    int win_hi[2];
    int glitch_tap = -1;
    int oor_tap    = -1;
    int m_tap      = 0;
    int m_cyc      = 0;

    function automatic bit tap_ok(input int t);
        for (int i = 0; i < 2; i++)
            if (t >= win_lo[i] && t <= win_hi[i]) return 1'b1;
        return 1'b0;
    endfunction

    always_comb begin
        RX_DATA = 8'h5A;
        if (tap_ok(m_tap) && !(m_tap == glitch_tap && m_cyc == 12)) RX_DATA = 8'hA5;
        RX_DELAY_LINE_OUT_OF_RANGE = (m_tap == oor_tap);
    end

    always @(posedge FAB_CLK) begin
        if (DELAY_LINE_LOAD) begin
            m_tap <= 0;
            m_cyc <= 0;
        end else if (DELAY_LINE_MOVE) begin
            m_tap <= m_tap + 1;
            m_cyc <= 0;
        end else begin
            m_cyc <= m_cyc + 1;
        end
    end

    // Pulse monitor
    int  cyc_n = 0, total_loads = 0, total_moves = 0, moves_since_load = 0;
    int  overlap = 0, consec = 0, last_move = 0, move_gap = 0;
    logic prev_move = 1'b0;

    always @(negedge FAB_CLK) begin
        cyc_n     <= cyc_n + 1;
        prev_move <= DELAY_LINE_MOVE;
        if (DELAY_LINE_LOAD && DELAY_LINE_MOVE) overlap <= overlap + 1;
        if (DELAY_LINE_MOVE && prev_move) consec <= consec + 1;
        if (DELAY_LINE_LOAD) begin
            total_loads      <= total_loads + 1;
            moves_since_load <= 0;
        end else if (DELAY_LINE_MOVE) begin
            total_moves      <= total_moves + 1;
            moves_since_load <= moves_since_load + 1;
            move_gap         <= cyc_n - last_move;
            last_move        <= cyc_n;
        end
    end

    task automatic set_win(input int lo0, input int hi0, input int lo1, input int hi1);
        win_lo[0] = lo0; win_hi[0] = hi0;
        win_lo[1] = lo1; win_hi[1] = hi1;
    endtask

    task automatic wait_tap(input int t);
        int n = 0;
        while (m_tap != t && n < 5000) begin
            @(negedge FAB_CLK);
            n++;
        end
        if (m_tap != t) check("wait_tap_timeout", m_tap, t);
    endtask

    task automatic run(input int es, input int ew, input int fin, input int err,
                       input bit poke);
        exp_t e;
        exp_t g;
        int   base_loads;
        int   n = 0;
        e.start = es; e.width = ew; e.fin = fin; e.err = err; e.park = fin; e.loads = 2;
        sb.push_back(e);
        base_loads  = total_loads;
        TRAIN_START = 1'b1;
        @(negedge FAB_CLK);
        TRAIN_START = 1'b0;
        check("busy_after_start", TRAIN_BUSY, 1);
        check("done_cleared", TRAIN_DONE, 0);
        check("load_pulse", DELAY_LINE_LOAD, 1);
        if (poke) begin
            wait_tap(40);
            check("tap_period", move_gap, 22);
            TRAIN_START = 1'b1;
            @(negedge FAB_CLK);
            TRAIN_START = 1'b0;
        end
        while (!TRAIN_DONE && n < 5000) begin
            @(negedge FAB_CLK);
            n++;
        end
        g = sb.pop_front();
        if (!TRAIN_DONE) begin
            check("done_timeout", 0, 1);
            return;
        end
        check("eye_start", EYE_START, g.start);
        check("eye_width", EYE_WIDTH, g.width);
        check("tap_final", TAP_FINAL, g.fin);
        check("train_err", TRAIN_ERR, g.err);
        check("park_moves", moves_since_load, g.park);
        check("load_count", total_loads - base_loads, g.loads);
        check("line_tap", m_tap, g.fin);
        @(negedge FAB_CLK);
        check("busy_released", TRAIN_BUSY, 0);
        check("done_sticky", TRAIN_DONE, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {DELAY_LINE_SEL, DELAY_LINE_LOAD, DELAY_LINE_DIRECTION, DELAY_LINE_MOVE,
                    TRAIN_BUSY, TRAIN_DONE, TRAIN_ERR, EYE_START, EYE_WIDTH, TAP_FINAL}, 0);
    endtask

    initial begin
        int base_moves;
        RESET_N     = 1'b0;
        TRAIN_START = 1'b0;
        set_win(20, 51, 300, 0);
        repeat (3) @(negedge FAB_CLK);
        check_all_zero("reset_outputs");
        RESET_N = 1'b1;
        @(negedge FAB_CLK);

        // Single window
        run(20, 32, 36, 0, 1'b0);
        // Two equal windows: earliest wins
        set_win(10, 17, 40, 47);
        run(10, 8, 14, 0, 1'b0);
        // Never matches
        set_win(300, 0, 300, 0);
        run(0, 0, 0, 1, 1'b0);
        // Sweep cut short by out-of-range at tap 60
        set_win(50, 100, 300, 0);
        oor_tap = 60;
        run(50, 10, 55, 0, 1'b0);
        oor_tap = -1;

        // Reset mid-sweep
        set_win(20, 51, 300, 0);
        TRAIN_START = 1'b1;
        @(negedge FAB_CLK);
        TRAIN_START = 1'b0;
        wait_tap(30);
        RESET_N = 1'b0;
        @(negedge FAB_CLK);
        check_all_zero("midsweep_reset_outputs");
        RESET_N    = 1'b1;
        base_moves = total_moves;
        repeat (100) @(negedge FAB_CLK);
        check("moves_after_reset", total_moves - base_moves, 0);
        check("idle_after_reset", TRAIN_BUSY, 0);
        run(20, 32, 36, 0, 1'b0);

        // One bad word at tap 35 splits the window; start pulse mid-sweep ignored
        glitch_tap = 35;
        run(36, 16, 44, 0, 1'b1);
        glitch_tap = -1;

        check("load_move_overlap", overlap, 0);
        check("move_back_to_back", consec, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
